// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types for the fetch-stage program-counter generator.
//   state_t : fetch FSM state (BOOT, RUN, HALT)
//   sel_t   : next-PC source picked by the priority encoder
// Optional feature macro used by the importing files: PC_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Listed in priority order, highest first.
  typedef enum logic [2:0] {
    SEL_TRAP  = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_JUMP  = 3'd2,
    SEL_HOLD  = 3'd3,
    SEL_SEQ   = 3'd4
  } sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational priority encoder for the next fetch PC.
// Priority: trap, EX redirect, ID jump (only when not stalled), hold, sequential.
//
// Ports
//   pc           in   ADDR_W  current fetch PC
//   pc_seq       in   ADDR_W  pc + INSTR_BYTES
//   stall        in   1       hazard hold
//   fetch_ready  in   1       imem accepted the current PC
//   redir_valid  in   1       EX redirect request
//   redir_target in   ADDR_W  EX redirect address
//   jump_valid   in   1       ID jump request
//   jump_target  in   ADDR_W  ID jump address
//   trap_req     in   1       exception request
//   sel          out  sel_t   winning source (the original source, even when
//                             a misaligned target is replaced by TRAP_VEC)
//   next_pc      out  ADDR_W  PC to load if the FSM takes this selection
//   bad_target   out  1       redirect/jump target was misaligned and replaced
//
// Macro PC_MISALIGN_TRAP_EN: when defined, a redirect/jump target whose low
// log2(INSTR_BYTES) bits are nonzero is replaced by TRAP_VEC and flagged.
// When undefined the target is passed through and bad_target stays 0.
// -----------------------------------------------------------------------------
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = 32'h80,
  parameter int              INSTR_BYTES = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_seq,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              trap_req,
  output sel_t              sel,
  output logic [ADDR_W-1:0] next_pc,
  output logic              bad_target
);

`ifdef PC_MISALIGN_TRAP_EN
  // INSTR_BYTES is a power of two, so INSTR_BYTES-1 selects the offset bits.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
`endif

  always_comb begin
    sel        = SEL_SEQ;
    next_pc    = pc_seq;
    bad_target = 1'b0;

    if (trap_req) begin
      sel     = SEL_TRAP;
      next_pc = TRAP_VEC;
    end else if (redir_valid) begin
      sel     = SEL_REDIR;
      next_pc = redir_target;
    end else if (jump_valid && !stall) begin
      // A stalled jump is dropped here; ID re-asserts it after the stall.
      sel     = SEL_JUMP;
      next_pc = jump_target;
    end else if (stall || !fetch_ready) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end

`ifdef PC_MISALIGN_TRAP_EN
    if ((sel == SEL_REDIR || sel == SEL_JUMP) && ((next_pc & ALIGN_MASK) != '0)) begin
      next_pc    = TRAP_VEC;
      bad_target = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the fetch stage. Holds the fetch PC, runs the
// BOOT/RUN/HALT control FSM and loads the next PC chosen by pc_next_sel.
//
// Ports
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   stall        in   1       hazard unit: hold PC
//   redir_valid  in   1       EX-stage branch taken / mispredict
//   redir_target in   ADDR_W  EX redirect address
//   jump_valid   in   1       ID-stage unconditional jump
//   jump_target  in   ADDR_W  ID jump address
//   trap_req     in   1       exception request (1-cycle pulse)
//   halt_req     in   1       enter HALT at next boundary
//   resume       in   1       leave HALT
//   fetch_ready  in   1       imem accepts pc_out this cycle
//   pc_out       out  ADDR_W  current fetch PC (registered)
//   pc_valid     out  1       pc_out is a real fetch request (registered)
//   pc_seq       out  ADDR_W  pc_out + INSTR_BYTES, wraps mod 2^ADDR_W
//   misalign     out  1       registered: last loaded target was misaligned
//
// Macro PC_MISALIGN_TRAP_EN enables the misaligned-target trap; without it
// misalign is constant 0 and targets are loaded unchanged.
// -----------------------------------------------------------------------------
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = 32'h0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = 32'h80,
  parameter int                INSTR_BYTES = 4,
  parameter int                BOOT_CYC    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              trap_req,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              misalign
);

  localparam int CNT_W = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
  // BOOT is left on the edge where the counter reaches BOOT_LAST. With
  // BOOT_CYC of 0 or 1 that is the first edge after reset release, which is
  // the earliest the registered state can move out of its reset value.
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_CYC > 0) ? BOOT_CYC - 1 : 0);

  state_t            state_reg;
  logic [CNT_W-1:0]  boot_cnt_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              valid_reg;
  logic              misalign_reg;

  sel_t              sel_next;
  logic [ADDR_W-1:0] pc_next;
  logic              bad_target;
  logic              halt_blocked;

  assign pc_seq   = pc_reg + ADDR_W'(INSTR_BYTES);
  assign pc_out   = pc_reg;
  assign pc_valid = valid_reg;
  assign misalign = misalign_reg;

  pc_next_sel #(
    .ADDR_W      (ADDR_W),
    .TRAP_VEC    (TRAP_VEC),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .pc           (pc_reg),
    .pc_seq       (pc_seq),
    .stall        (stall),
    .fetch_ready  (fetch_ready),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .trap_req     (trap_req),
    .sel          (sel_next),
    .next_pc      (pc_next),
    .bad_target   (bad_target)
  );

  // A trap or redirect in the same cycle takes precedence over halt_req.
  assign halt_blocked = (sel_next == SEL_TRAP) || (sel_next == SEL_REDIR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      boot_cnt_reg <= '0;
      pc_reg       <= RESET_VEC;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      // misalign is a one-cycle flag for the load that just happened.
      misalign_reg <= 1'b0;
      case (state_reg)
        BOOT: begin
          if (boot_cnt_reg == BOOT_LAST) begin
            state_reg <= RUN;
            valid_reg <= 1'b1;
          end else begin
            boot_cnt_reg <= boot_cnt_reg + 1'b1;
          end
        end

        RUN: begin
          if (halt_req && !halt_blocked) begin
            // PC is frozen at the halt boundary; the request is withdrawn.
            state_reg <= HALT;
            valid_reg <= 1'b0;
          end else begin
            pc_reg       <= pc_next;
            misalign_reg <= bad_target;
          end
        end

        HALT: begin
          // Only a trap moves the PC while halted; redirects/jumps are ignored.
          if (trap_req) begin
            pc_reg    <= TRAP_VEC;
            state_reg <= RUN;
            valid_reg <= 1'b1;
          end else if (resume) begin
            state_reg <= RUN;
            valid_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= BOOT;
          boot_cnt_reg <= '0;
          pc_reg       <= RESET_VEC;
          valid_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Directed vectors with hand-computed expectations for pc_gen (default
// parameters: RESET_VEC=0, TRAP_VEC=0x80, INSTR_BYTES=4, BOOT_CYC=2).
// Misalign expectations follow PC_MISALIGN_TRAP_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        trap_req;
  logic        halt_req;
  logic        resume;
  logic        fetch_ready;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_seq;
  logic        misalign;

  int tests_run;
  int tests_failed;

  pc_gen dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .trap_req     (trap_req),
    .halt_req     (halt_req),
    .resume       (resume),
    .fetch_ready  (fetch_ready),
    .pc_out       (pc_out),
    .pc_valid     (pc_valid),
    .pc_seq       (pc_seq),
    .misalign     (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    stall        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    jump_valid   = 1'b0;
    jump_target  = 32'h0;
    trap_req     = 1'b0;
    halt_req     = 1'b0;
    resume       = 1'b0;
    fetch_ready  = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);

    // Boot: two invalid cycles, then 0,4,8
    reset = 1'b0;
    check("boot0_valid", {31'd0, pc_valid}, 32'd0);
    step();
    check("boot1_valid", {31'd0, pc_valid}, 32'd0);
    check("boot1_pc", pc_out, 32'h0);
    step();
    check("run0_valid", {31'd0, pc_valid}, 32'd1);
    check("run0_pc", pc_out, 32'h0);
    step();
    check("run1_pc", pc_out, 32'h4);
    step();
    check("run2_pc", pc_out, 32'h8);
    check("run2_seq", pc_seq, 32'hC);

    // Redirect beats stall and jump
    redir_valid = 1'b1; redir_target = 32'h100;
    stall = 1'b1; jump_valid = 1'b1; jump_target = 32'h200;
    step();
    check("redir_over_jump", pc_out, 32'h100);
    idle_inputs();

    // Jump to 0x10, then 3-cycle stall, then sequential
    jump_valid = 1'b1; jump_target = 32'h10;
    step();
    check("jump_pc", pc_out, 32'h10);
    idle_inputs();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), pc_out, 32'h10);
    end
    stall = 1'b0;
    step();
    check("stall_release", pc_out, 32'h14);

    // fetch_ready low holds
    fetch_ready = 1'b0;
    step();
    check("not_ready_hold", pc_out, 32'h14);
    fetch_ready = 1'b1;

    // Stalled jump is dropped
    stall = 1'b1; jump_valid = 1'b1; jump_target = 32'h300;
    step();
    check("stalled_jump_hold", pc_out, 32'h14);
    idle_inputs();
    step();
    check("stalled_jump_dropped", pc_out, 32'h18);

    // Halt at 0x40
    redir_valid = 1'b1; redir_target = 32'h40;
    step();
    check("redir_40", pc_out, 32'h40);
    idle_inputs();
    halt_req = 1'b1;
    step();
    check("halt_pc", pc_out, 32'h40);
    check("halt_valid", {31'd0, pc_valid}, 32'd0);
    halt_req = 1'b0;
    step();
    check("halt_hold_pc", pc_out, 32'h40);
    redir_valid = 1'b1; redir_target = 32'h500;
    step();
    check("halt_ignores_redir", pc_out, 32'h40);
    check("halt_ignores_redir_valid", {31'd0, pc_valid}, 32'd0);
    idle_inputs();

    // Trap in HALT
    trap_req = 1'b1;
    step();
    check("halt_trap_pc", pc_out, 32'h80);
    check("halt_trap_valid", {31'd0, pc_valid}, 32'd1);
    idle_inputs();
    step();
    check("after_trap_seq", pc_out, 32'h84);

    // halt_req + resume: halt wins in RUN, resume wins in HALT
    halt_req = 1'b1; resume = 1'b1;
    step();
    check("both_in_run_valid", {31'd0, pc_valid}, 32'd0);
    check("both_in_run_pc", pc_out, 32'h84);
    step();
    check("both_in_halt_valid", {31'd0, pc_valid}, 32'd1);
    check("both_in_halt_pc", pc_out, 32'h84);
    idle_inputs();
    step();
    check("resume_seq", pc_out, 32'h88);

    // Redirect blocks halt
    redir_valid = 1'b1; redir_target = 32'h200; halt_req = 1'b1;
    step();
    check("redir_blocks_halt_pc", pc_out, 32'h200);
    check("redir_blocks_halt_valid", {31'd0, pc_valid}, 32'd1);
    idle_inputs();
    step();
    check("redir_blocks_halt_seq", pc_out, 32'h204);

    // Trap beats redirect in RUN
    trap_req = 1'b1; redir_valid = 1'b1; redir_target = 32'h300;
    step();
    check("trap_over_redir", pc_out, 32'h80);
    idle_inputs();

    // Wrap-around
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    step();
    check("wrap_top", pc_out, 32'hFFFF_FFFC);
    check("wrap_seq", pc_seq, 32'h0);
    idle_inputs();
    step();
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_valid", {31'd0, pc_valid}, 32'd1);
    check("wrap_no_flag", {31'd0, misalign}, 32'd0);

    // Misaligned jump
    jump_valid = 1'b1; jump_target = 32'h102;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_pc", pc_out, 32'h80);
    check("misalign_flag", {31'd0, misalign}, 32'd1);
`else
    check("misalign_pc", pc_out, 32'h102);
    check("misalign_flag", {31'd0, misalign}, 32'd0);
`endif
    idle_inputs();
    step();
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_next_pc", pc_out, 32'h84);
`else
    check("misalign_next_pc", pc_out, 32'h106);
`endif
    check("misalign_clear", {31'd0, misalign}, 32'd0);

    // Asynchronous reset mid-operation
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_pc", pc_out, 32'h0);
    check("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("reboot_valid", {31'd0, pc_valid}, 32'd0);
    step();
    check("reboot_run_valid", {31'd0, pc_valid}, 32'd1);
    check("reboot_run_pc", pc_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
